// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: single-outstanding I-cache fetch, small FIFO to decoder, redirect flush.
// Optional macro FETCH_JAL_PREDICT_EN: predict JAL targets instead of pc+4.
module ins_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter int          QADDR_W     = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_ins,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc,
  input  logic        dec_ready
);

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } fq_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

  localparam logic [QADDR_W:0] FULL = (QADDR_W+1)'(QUEUE_DEPTH);

  state_t               state, state_nxt;
  fq_entry_t            q [QUEUE_DEPTH];
  logic [QADDR_W-1:0]   head, tail;
  logic [QADDR_W:0]     count;
  logic [31:0]          pc, pred_pc, stale_addr;
  logic                 push, pop;

`ifdef FETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_imm;
  assign is_jal  = (ic_resp_ins[6:0] == 7'b1101111);
  assign jal_imm = {{11{ic_resp_ins[31]}}, ic_resp_ins[31], ic_resp_ins[19:12],
                    ic_resp_ins[20], ic_resp_ins[30:21], 1'b0};
  assign pred_pc = is_jal ? pc + jal_imm : pc + 32'd4;
`else
  assign pred_pc = pc + 32'd4;
`endif

  // Redirect wins over everything, so it masks both queue operations.
  assign push = (state == ST_WAIT) && ic_resp_valid && !redirect_valid;
  assign pop  = dec_valid && dec_ready && !redirect_valid;

  assign dec_valid    = (count != '0);
  assign dec_ins      = q[head].ins;
  assign dec_pc       = q[head].pc;
  assign dec_pred_pc  = q[head].pred_pc;
  assign ic_req_valid = (state != ST_IDLE);
  // While draining a flushed request the cache still sees the old address.
  assign ic_req_addr  = (state == ST_DISCARD) ? stale_addr : pc;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!redirect_valid && count < FULL) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (redirect_valid)     state_nxt = ic_resp_valid ? ST_IDLE : ST_DISCARD;
        else if (ic_resp_valid) state_nxt = ST_IDLE;
      end
      ST_DISCARD: if (!redirect_valid && ic_resp_valid) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= ST_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else if (rdy_in) begin
      if (state == ST_WAIT && redirect_valid && !ic_resp_valid) stale_addr <= pc;
      if (redirect_valid) begin
        pc    <= redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q[tail] <= '{ins: ic_resp_ins, pc: pc, pred_pc: pred_pc};
          tail    <= tail + 1'b1;
          pc      <= pred_pc;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: fetch, fill, redirect, JAL predict, stall, async reset.
module tb_ins_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_ins;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_ins;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;
  logic        dec_ready;

  int tests = 0;
  int fails = 0;

`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] JAL_TGT = 32'h120;
`else
  localparam logic [31:0] JAL_TGT = 32'h24;
`endif

  ins_fetch_queue #(.QUEUE_DEPTH(4), .QADDR_W(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_ins(ic_resp_ins),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ins(dec_ins), .dec_pc(dec_pc),
    .dec_pred_pc(dec_pred_pc), .dec_ready(dec_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; ic_resp_valid = 1'b0; ic_resp_ins = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
    chk("rst_req_addr",  ic_req_addr, 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_ins",   dec_ins, 32'h0);
    chk("rst_dec_pc",    dec_pc, 32'h0);
    chk("rst_dec_pred",  dec_pred_pc, 32'h0);
    step();
    rst_in = 1'b1;
    chk("idle_req_valid", 32'(ic_req_valid), 32'd0);

    // First fetch, response after two WAIT cycles
    step();
    chk("t1_req_valid", 32'(ic_req_valid), 32'd1);
    chk("t1_req_addr",  ic_req_addr, 32'h0);
    step();
    chk("t1_req_hold",  ic_req_addr, 32'h0);
    ic_resp_valid = 1'b1; ic_resp_ins = 32'h00000013;
    step();
    ic_resp_valid = 1'b0;
    chk("t1_dec_valid", 32'(dec_valid), 32'd1);
    chk("t1_dec_pc",    dec_pc, 32'h0);
    chk("t1_dec_pred",  dec_pred_pc, 32'h4);
    chk("t1_dec_ins",   dec_ins, 32'h00000013);
    chk("t1_gap",       32'(ic_req_valid), 32'd0);
    step();
    chk("t1_next_addr", ic_req_addr, 32'h4);

    // Fill the queue with dec_ready low
    for (int k = 1; k <= 3; k++) begin
      chk("t2_fill_addr", ic_req_addr, 32'(4 * k));
      ic_resp_valid = 1'b1; ic_resp_ins = 32'h1000 + 32'(k);
      step();
      ic_resp_valid = 1'b0;
      step();
    end
    chk("t2_full_no_req", 32'(ic_req_valid), 32'd0);
    step();
    chk("t2_full_no_req2", 32'(ic_req_valid), 32'd0);
    chk("t2_head_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("t2_pop_head", dec_pc, 32'h4);
    chk("t2_pop_ins",  dec_ins, 32'h1001);
    step();
    chk("t2_req_after_pop", 32'(ic_req_valid), 32'd1);
    chk("t2_req_addr",      ic_req_addr, 32'h10);

    // Redirect during WAIT, response arrives later and is dropped
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed",     32'(dec_valid), 32'd0);
    chk("t3_discard_vld", 32'(ic_req_valid), 32'd1);
    chk("t3_stale_addr",  ic_req_addr, 32'h10);
    step();
    step();
    chk("t3_still_empty", 32'(dec_valid), 32'd0);
    ic_resp_valid = 1'b1; ic_resp_ins = 32'hdeadbeef;
    step();
    ic_resp_valid = 1'b0;
    chk("t3_dropped",    32'(dec_valid), 32'd0);
    chk("t3_idle_gap",   32'(ic_req_valid), 32'd0);
    step();
    chk("t3_new_addr",   ic_req_addr, 32'h100);
    chk("t3_new_req",    32'(ic_req_valid), 32'd1);

    // Redirect with same-cycle response and pop
    ic_resp_valid = 1'b1; ic_resp_ins = 32'h00000013;
    step();
    ic_resp_valid = 1'b0;
    step();
    chk("t4_queued_pc", dec_pc, 32'h100);
    chk("t4_req_addr",  ic_req_addr, 32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    ic_resp_valid = 1'b1; ic_resp_ins = 32'h12345678; dec_ready = 1'b1;
    step();
    redirect_valid = 1'b0; ic_resp_valid = 1'b0; dec_ready = 1'b0;
    chk("t4_empty",      32'(dec_valid), 32'd0);
    chk("t4_idle",       32'(ic_req_valid), 32'd0);
    step();
    chk("t4_no_discard", ic_req_addr, 32'h200);
    chk("t4_req",        32'(ic_req_valid), 32'd1);

    // JAL prediction at pc 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20; ic_resp_valid = 1'b1;
    step();
    redirect_valid = 1'b0; ic_resp_valid = 1'b0;
    step();
    chk("t5_addr", ic_req_addr, 32'h20);
    ic_resp_valid = 1'b1; ic_resp_ins = 32'h1000006F;
    step();
    ic_resp_valid = 1'b0;
    chk("t5_dec_pc",   dec_pc, 32'h20);
    chk("t5_dec_pred", dec_pred_pc, JAL_TGT);
    chk("t5_dec_ins",  dec_ins, 32'h1000006F);
    step();
    chk("t5_next_addr", ic_req_addr, JAL_TGT);

    // Global stall in WAIT with a pop pending
    rdy_in = 1'b0; dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_stall_valid", 32'(dec_valid), 32'd1);
      chk("t6_stall_pc",    dec_pc, 32'h20);
      chk("t6_stall_req",   32'(ic_req_valid), 32'd1);
      chk("t6_stall_addr",  ic_req_addr, JAL_TGT);
    end
    rdy_in = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("t6_popped",     32'(dec_valid), 32'd0);
    chk("t6_resume_req", 32'(ic_req_valid), 32'd1);
    chk("t6_resume_addr", ic_req_addr, JAL_TGT);
    ic_resp_valid = 1'b1; ic_resp_ins = 32'h00100093;
    step();
    ic_resp_valid = 1'b0;
    chk("t6_push_pc",   dec_pc, JAL_TGT);
    chk("t6_push_pred", dec_pred_pc, JAL_TGT + 32'd4);
    chk("t6_push_ins",  dec_ins, 32'h00100093);
    step();
    chk("t6_next_addr", ic_req_addr, JAL_TGT + 32'd4);

    // Simultaneous push and pop keeps one entry
    ic_resp_valid = 1'b1; ic_resp_ins = 32'h00200113; dec_ready = 1'b1;
    step();
    ic_resp_valid = 1'b0; dec_ready = 1'b0;
    chk("t7_valid", 32'(dec_valid), 32'd1);
    chk("t7_pc",    dec_pc, JAL_TGT + 32'd4);
    chk("t7_pred",  dec_pred_pc, JAL_TGT + 32'd8);

    // Asynchronous reset mid-run
    #2 rst_in = 1'b0;
    #1;
    chk("ar_dec_valid", 32'(dec_valid), 32'd0);
    chk("ar_req_valid", 32'(ic_req_valid), 32'd0);
    chk("ar_req_addr",  ic_req_addr, 32'h0);
    chk("ar_dec_pc",    dec_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
